// File: rtl/cond_pkg.sv
// Shared types for the conditional-execution pipeline: condition codes,
// flag bit positions and IT-block FSM states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'd0,  NE = 4'd1,  CS = 4'd2,  CC = 4'd3,
    MI = 4'd4,  PL = 4'd5,  VS = 4'd6,  VC = 4'd7,
    HI = 4'd8,  LS = 4'd9,  GE = 4'd10, LT = 4'd11,
    GT = 4'd12, LE = 4'd13, AL = 4'd14, NV = 4'd15
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {IT_IDLE = 1'b0, IT_ACTIVE = 1'b1} it_state_e;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition-code evaluator against a {N,Z,C,V} flag word.
module cond_check
  import cond_pkg::*;
(
  input  cond_e      i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FLAG_N];
  assign w_z = i_flags[FLAG_Z];
  assign w_c = i_flags[FLAG_C];
  assign w_v = i_flags[FLAG_V];

  always_comb begin
    o_pass = 1'b0;
    case (i_cond)
      EQ: o_pass = w_z;
      NE: o_pass = ~w_z;
      CS: o_pass = w_c;
      CC: o_pass = ~w_c;
      MI: o_pass = w_n;
      PL: o_pass = ~w_n;
      VS: o_pass = w_v;
      VC: o_pass = ~w_v;
      HI: o_pass = w_c & ~w_z;
      LS: o_pass = ~w_c | w_z;
      GE: o_pass = (w_n == w_v);
      LT: o_pass = (w_n != w_v);
      GT: o_pass = ~w_z & (w_n == w_v);
      LE: o_pass = w_z | (w_n != w_v);
      AL: o_pass = 1'b1;
      NV: o_pass = 1'b0;
      default: o_pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic_pipe.sv
// Pipelined conditional-execution unit: grouped NZCV register, write gating,
// IT-block predication FSM. Define COND_SQUASH_CNT_EN to build the squash counter.
module cond_logic_pipe
  import cond_pkg::*;
#(
  parameter int FLAG_GROUPS = 2,
  parameter int IT_DEPTH    = 4,
  parameter int LEN_W       = $clog2(IT_DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid,
  input  logic                   stall,
  input  logic                   flush,
  input  logic [3:0]             cond,
  input  logic [3:0]             alu_flags,
  input  logic [FLAG_GROUPS-1:0] flag_w,
  input  logic                   pcs,
  input  logic                   reg_w,
  input  logic                   mem_w,
  input  logic                   it_start,
  input  logic [3:0]             it_cond,
  input  logic [LEN_W-1:0]       it_len,
  input  logic [IT_DEPTH-1:0]    it_then,
  output logic                   pc_src,
  output logic                   reg_write,
  output logic                   mem_write,
  output logic                   cond_ex,
  output logic [3:0]             flags,
  output logic                   it_active,
  output logic [LEN_W-1:0]       it_remaining,
  output logic [31:0]            squash_count
);

  localparam int GW = 4 / FLAG_GROUPS;

  it_state_e            r_state, w_state_nxt;
  logic [LEN_W-1:0]     r_it_len, r_it_rem, w_len_nxt, w_rem_nxt;
  logic [LEN_W-1:0]     w_slot, w_len_clamp;
  logic [3:0]           r_it_cond, w_itc_nxt;
  logic [IT_DEPTH-1:0]  r_it_then, w_itt_nxt;
  logic [3:0]           r_flags;
  logic                 w_commit, w_then_bit, w_pass;
  cond_e                w_eff_cond;

  assign w_commit    = valid & ~stall & ~flush;
  assign w_len_clamp = (it_len > LEN_W'(IT_DEPTH)) ? LEN_W'(IT_DEPTH) : it_len;

  // Inside an IT block the slot's then/else bit selects it_cond or its inverse.
  always_comb begin
    w_slot     = r_it_len - r_it_rem;
    w_then_bit = 1'b0;
    for (int k = 0; k < IT_DEPTH; k++)
      if (w_slot == LEN_W'(k)) w_then_bit = r_it_then[k];
    if (r_state == IT_ACTIVE)
      w_eff_cond = cond_e'(w_then_bit ? r_it_cond : {r_it_cond[3:1], ~r_it_cond[0]});
    else
      w_eff_cond = cond_e'(cond);
  end

  cond_check u_check (
    .i_cond  (w_eff_cond),
    .i_flags (r_flags),
    .o_pass  (w_pass)
  );

  assign cond_ex   = w_commit & w_pass;
  assign pc_src    = pcs   & cond_ex;
  assign reg_write = reg_w & cond_ex;
  assign mem_write = mem_w & cond_ex;
  assign flags     = r_flags;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flags <= '0;
    end else begin
      for (int g = 0; g < FLAG_GROUPS; g++)
        if (cond_ex & flag_w[g]) r_flags[g*GW +: GW] <= alu_flags[g*GW +: GW];
    end
  end

  // IT FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IT_IDLE;
      r_it_len  <= '0;
      r_it_rem  <= '0;
      r_it_cond <= '0;
      r_it_then <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_it_len  <= w_len_nxt;
      r_it_rem  <= w_rem_nxt;
      r_it_cond <= w_itc_nxt;
      r_it_then <= w_itt_nxt;
    end
  end

  // IT FSM: next state. Flush beats slot consumption; a taken branch ends the block.
  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_it_len;
    w_rem_nxt   = r_it_rem;
    w_itc_nxt   = r_it_cond;
    w_itt_nxt   = r_it_then;
    case (r_state)
      IT_IDLE: begin
        if (cond_ex & it_start & (it_len != '0)) begin
          w_state_nxt = IT_ACTIVE;
          w_len_nxt   = w_len_clamp;
          w_rem_nxt   = w_len_clamp;
          w_itc_nxt   = it_cond;
          w_itt_nxt   = it_then;
        end
      end
      IT_ACTIVE: begin
        if (flush) begin
          w_state_nxt = IT_IDLE;
          w_rem_nxt   = '0;
        end else if (w_commit) begin
          if ((r_it_rem == LEN_W'(1)) || (pcs & cond_ex)) begin
            w_state_nxt = IT_IDLE;
            w_rem_nxt   = '0;
          end else begin
            w_rem_nxt   = r_it_rem - LEN_W'(1);
          end
        end
      end
      default: w_state_nxt = IT_IDLE;
    endcase
  end

  // IT FSM: outputs
  always_comb begin
    it_active    = (r_state == IT_ACTIVE);
    it_remaining = r_it_rem;
  end

`ifdef COND_SQUASH_CNT_EN
  logic [31:0] r_squash;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_squash <= '0;
    else if (w_commit & ~w_pass & ~(&r_squash))
      r_squash <= r_squash + 32'd1;
  end

  assign squash_count = r_squash;
`else
  assign squash_count = '0;
`endif

endmodule

// File: doc/cond_logic_pipe.md
Name: cond_logic_pipe

Overview:
- Parametrised successor to the CPU control unit's conditional-execution logic, for the pipelined core.
- Holds the NZCV flag register with a configurable number of independently written flag groups.
- Evaluates ARM condition codes and gates PC/register/memory write enables.
- Adds stall/flush handling and an IT-block state machine that predicates up to IT_DEPTH following instructions.

Parameters:
FLAG_GROUPS, 2, number of independently write-enabled flag groups; legal 1, 2, 4; each group is 4/FLAG_GROUPS bits wide, group FLAG_GROUPS-1 holds N
IT_DEPTH, 4, maximum instructions covered by one IT block; legal 1..8
LEN_W, $clog2(IT_DEPTH+1), width of IT length and remaining count

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid  in  1  instruction in execute stage is valid
stall  in  1  execute stage held this cycle; instruction does not commit
flush  in  1  execute stage squashed this cycle
cond  in  4  instruction condition field
alu_flags  in  4  {N,Z,C,V} from ALU
flag_w  in  FLAG_GROUPS  per-group flag write request
pcs  in  1  instruction writes PC
reg_w  in  1  instruction writes register file
mem_w  in  1  instruction writes memory
it_start  in  1  instruction is an IT instruction
it_cond  in  4  IT base condition
it_len  in  LEN_W  number of predicated instructions
it_then  in  IT_DEPTH  bit k=1: slot k uses it_cond; bit k=0: slot k uses the inverse condition
pc_src  out  1  gated PC write
reg_write  out  1  gated register write
mem_write  out  1  gated memory write
cond_ex  out  1  condition passed for the current instruction
flags  out  4  registered {N,Z,C,V}
it_active  out  1  IT FSM in ACTIVE
it_remaining  out  LEN_W  slots left in the current IT block
squash_count  out  32  committed instructions that failed their condition (see Optional Feature)

Behaviour:
- commit = valid & ~stall & ~flush.
- Effective condition:
  - IDLE: cond.
  - ACTIVE: it_cond if it_then[slot], otherwise it_cond with bit0 inverted; slot = it_len_q - it_remaining.
  - In ACTIVE the instruction cond field is ignored.
- Condition check, combinational from registered flags only (no same-cycle forwarding):
  - Standard ARM codes EQ..LE.
  - AL (1110) is always true.
  - 1111 (NV) is always false.
- cond_ex = commit & check(effective condition).
- Write gating: pc_src = pcs & cond_ex; reg_write = reg_w & cond_ex; mem_write = mem_w & cond_ex. Zero during stall or flush.
- Flag register:
  - Group g loads its alu_flags slice on the clock edge when cond_ex & flag_w[g].
  - Unwritten groups hold their value.
  - New flags are visible to the next instruction's check.
- IT FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE when cond_ex & it_start & it_len != 0. Latch it_cond, it_then and len = min(it_len, IT_DEPTH); it_remaining = len.
  - it_len == 0 is a no-op; the FSM stays IDLE.
  - ACTIVE: each commit consumes one slot whether or not it passes, and it_remaining decrements. Return to IDLE when the slot with it_remaining==1 commits.
  - ACTIVE: pc_src asserted terminates the block (go to IDLE, remaining 0) after that slot.
  - ACTIVE: it_start is ignored; nested IT is unsupported and the instruction is treated as an ordinary predicated slot.
  - flush in ACTIVE aborts the block: IDLE, remaining 0. flush takes priority over it_start and slot consumption in the same cycle.
  - stall freezes all state.
- Reset (asynchronous, any time, including mid-IT):
  - flags = 0, FSM IDLE, it_remaining = 0, squash_count = 0.
  - pc_src/reg_write/mem_write follow inputs combinationally; they are 0 whenever valid = 0.

Optional Feature:
- Macro COND_SQUASH_CNT_EN.
- Defined: 32-bit counter increments on each commit with cond_ex = 0, saturating at 0xFFFFFFFF, cleared by reset.
- Undefined: no counter logic; squash_count is tied to 0.

Decomposition:
- Package cond_pkg:
  - cond_e enum (EQ=0 … AL=14, NV=15).
  - Flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - it_state_e {IT_IDLE, IT_ACTIVE}.
- Sub-module cond_check: purely combinational, input cond_e plus 4 flags, output pass.

Test Plan:
- Flag groups: FLAG_GROUPS=2, alu_flags=4'b0100, flag_w=2'b10, cond=AL, then cond=EQ -> flags=4'b0100, second instruction cond_ex=1; with flag_w=2'b01 instead -> flags N/Z unchanged.
- Gating: flags Z=1, cond=NE, reg_w=mem_w=pcs=1 -> all write outputs 0, flags unchanged even with flag_w=2'b11.
- IT sequence: IT with it_cond=EQ, it_len=3, it_then=3'b101, Z=1 -> slot passes 1,0,1; it_remaining 3,2,1,0; it_active drops after slot 2.
- Stall and flush: stall asserted in slot 1 -> remaining frozen, outputs 0; flush in slot 1 -> IDLE, remaining 0; flush with it_start -> stays IDLE.
- Reset and clamp: reset asserted asynchronously mid-IT with remaining=2 -> immediately IDLE, flags=0; it_len=7 with IT_DEPTH=4 -> remaining=4.
- Squash counter: with COND_SQUASH_CNT_EN, 5 committed failing instructions plus 1 stalled failing instruction -> squash_count=5; without the macro -> squash_count=0.
